prbs_checker: RTL and testbench

Serial PRBS checker for the 16-bit LFSR random generator: x^16+x^14+x^13+x^11, left-shift, new bit enters at the LSB. It sits at the receiving end of a link or loopback path carrying that generator's bit stream. It self-synchronises a shadow LFSR from received bits, then predicts each next bit, flags mismatches and keeps saturating error and bit counts. Used for link bring-up and generator validation on the board.

---
 rtl/prbs_checker.sv | 165 ++++++++++++++++
 tb/tb_prbs_checker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_checker
//  Description : Self-synchronising serial checker for the x^16+x^14+x^13+x^11
//                PRBS stream. Optional loss-of-lock window: PRBS_CHK_LOSS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs_checker #(
   parameter int LOSS_WIN    = 64,
   parameter int LOSS_THRESH = 8,
   parameter int CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             in_valid_i,
   input  logic             in_bit_i,
   input  logic             clear_counts_i,
   output logic             locked_o,
   output logic             err_pulse_o,
   output logic [CNT_W-1:0] err_count_o,
   output logic [CNT_W-1:0] bit_count_o
);

   localparam logic [0:0]       ST_SEED  = 1'b0;
   localparam logic [0:0]       ST_CHECK = 1'b1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [0:0]       state_q,   state_d;
   logic [15:0]      shadow_q,  shadow_d;
   logic [3:0]       fill_q,    fill_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             pulse_q,   pulse_d;

   logic             pred;
   logic             miss;
   logic [15:0]      seed_next;
   logic             lose;

   assign pred      = shadow_q[15] ^ shadow_q[13] ^ shadow_q[12] ^ shadow_q[10];
   assign miss      = in_bit_i ^ pred;
   assign seed_next = {shadow_q[14:0], in_bit_i};

`ifdef PRBS_CHK_LOSS_EN
   localparam int WC_W = $clog2(LOSS_WIN);
   localparam int WE_W = $clog2(LOSS_THRESH + 1);

   logic [WC_W-1:0] win_cnt_q, win_cnt_d;
   logic [WE_W-1:0] win_err_q, win_err_d;
   logic [WE_W-1:0] win_err_base;
   logic [WE_W-1:0] win_err_inc;

   // The wrapping bit opens the new window, so its own error lands there.
   assign win_err_base = (win_cnt_q == WC_W'(LOSS_WIN - 1)) ? '0 : win_err_q;
   assign win_err_inc  = win_err_base + 1'b1;

   always_comb begin
      win_cnt_d = win_cnt_q;
      win_err_d = win_err_q;
      lose      = 1'b0;
      if (state_q == ST_CHECK && in_valid_i) begin
         win_cnt_d = win_cnt_q + 1'b1;
         win_err_d = win_err_base;
         if (miss) begin
            win_err_d = win_err_inc;
            if (win_err_inc == WE_W'(LOSS_THRESH)) begin
               lose      = 1'b1;
               win_cnt_d = '0;
               win_err_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         win_cnt_q <= '0;
         win_err_q <= '0;
      end else begin
         win_cnt_q <= win_cnt_d;
         win_err_q <= win_err_d;
      end
   end
`else
   logic unused_cfg;

   assign lose       = 1'b0;
   assign unused_cfg = (LOSS_WIN > LOSS_THRESH);
`endif

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      fill_d    = fill_q;
      err_cnt_d = err_cnt_q;
      bit_cnt_d = bit_cnt_q;
      pulse_d   = 1'b0;

      if (in_valid_i) begin
         case (state_q)
            ST_SEED: begin
               shadow_d = seed_next;
               fill_d   = fill_q + 1'b1;
               // An all-zero seed is the LFSR lockup state; refill instead.
               if (fill_q == 4'd15) begin
                  fill_d = '0;
                  if (seed_next != 16'h0000) begin
                     state_d = ST_CHECK;
                  end
               end
            end
            ST_CHECK: begin
               shadow_d = {shadow_q[14:0], pred};
               if (bit_cnt_q != CNT_MAX) begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
               if (miss) begin
                  pulse_d = 1'b1;
                  if (err_cnt_q != CNT_MAX) begin
                     err_cnt_d = err_cnt_q + 1'b1;
                  end
               end
               if (lose) begin
                  state_d = ST_SEED;
                  fill_d  = '0;
               end
            end
            default: begin
               state_d = ST_SEED;
               fill_d  = '0;
            end
         endcase
      end

      if (clear_counts_i) begin
         err_cnt_d = '0;
         bit_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_SEED;
         shadow_q  <= '0;
         fill_q    <= '0;
         err_cnt_q <= '0;
         bit_cnt_q <= '0;
         pulse_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         fill_q    <= fill_d;
         err_cnt_q <= err_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         pulse_q   <= pulse_d;
      end
   end

   assign locked_o    = (state_q == ST_CHECK);
   assign err_pulse_o = pulse_q;
   assign err_count_o = err_cnt_q;
   assign bit_count_o = bit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_prbs_checker
//  Description : Scoreboard bench for prbs_checker; honours PRBS_CHK_LOSS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs_checker;

   localparam int CNT_W       = 16;
   localparam int LOSS_WIN    = 64;
   localparam int LOSS_THRESH = 8;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_bit;
   logic             clear_counts;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] bit_count;

   prbs_checker #(
      .LOSS_WIN    (LOSS_WIN),
      .LOSS_THRESH (LOSS_THRESH),
      .CNT_W       (CNT_W)
   ) u_dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .in_valid_i     (in_valid),
      .in_bit_i       (in_bit),
      .clear_counts_i (clear_counts),
      .locked_o       (locked),
      .err_pulse_o    (err_pulse),
      .err_count_o    (err_count),
      .bit_count_o    (bit_count)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_bad  = 0;
   int n_pulse = 0;
   int n_drop  = 0;
   logic prev_locked = 1'b0;

   logic [2*CNT_W+1:0] exp_q[$];

   // Reference model state
   logic [15:0] m_shadow;
   int          m_fill, m_err, m_bits, m_wc, m_we;
   logic        m_locked, m_pulse;
   logic [15:0] gen;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic gen_next(output logic b);
      b   = gen[15] ^ gen[13] ^ gen[12] ^ gen[10];
      gen = {gen[14:0], b};
   endtask

   task automatic model_step(input logic rst, input logic v, input logic b, input logic clr);
      logic p, e;
      m_pulse = 1'b0;
      if (rst) begin
         m_shadow = '0; m_fill = 0; m_err = 0; m_bits = 0;
         m_wc = 0; m_we = 0; m_locked = 1'b0;
         return;
      end
      if (v) begin
         if (!m_locked) begin
            m_shadow = {m_shadow[14:0], b};
            m_fill++;
            if (m_fill == 16) begin
               m_fill = 0;
               if (m_shadow != 16'h0) m_locked = 1'b1;
            end
         end else begin
            p = m_shadow[15] ^ m_shadow[13] ^ m_shadow[12] ^ m_shadow[10];
            e = (b != p);
            m_shadow = {m_shadow[14:0], p};
            if (m_bits < CNT_MAX) m_bits++;
            if (e) begin
               m_pulse = 1'b1;
               if (m_err < CNT_MAX) m_err++;
            end
`ifdef PRBS_CHK_LOSS_EN
            if (m_wc == LOSS_WIN - 1) begin
               m_wc = 0;
               m_we = 0;
            end else begin
               m_wc++;
            end
            if (e) begin
               m_we++;
               if (m_we == LOSS_THRESH) begin
                  m_locked = 1'b0; m_fill = 0; m_wc = 0; m_we = 0;
               end
            end
`endif
         end
      end
      if (clr) begin
         m_err  = 0;
         m_bits = 0;
      end
   endtask

   task automatic cycle(input logic rst, input logic v, input logic b, input logic clr);
      logic [2*CNT_W+1:0] exp;
      reset = rst; in_valid = v; in_bit = b; clear_counts = clr;
      model_step(rst, v, b, clr);
      exp_q.push_back({m_locked, m_pulse, CNT_W'(m_err), CNT_W'(m_bits)});
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      check_val("cycle", {locked, err_pulse, err_count, bit_count}, exp);
      if (err_pulse) n_pulse++;
      if (prev_locked && !locked) n_drop++;
      prev_locked = locked;
   endtask

   task automatic stream(input int n, input int inv_lo, input int inv_hi);
      logic b;
      for (int i = 0; i < n; i++) begin
         gen_next(b);
         cycle(1'b0, 1'b1, b ^ ((i >= inv_lo) && (i <= inv_hi)), 1'b0);
      end
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n_pulse = 0;
      n_drop  = 0;
   endtask

   initial begin
      #1ms;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic b;
      // Reset state
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check_val("reset_state", {locked, err_pulse, err_count, bit_count}, 64'd0);
      do_reset();

      // Clean 1000-bit stream
      gen = 16'hACE1;
      stream(15, -1, -1);
      check_val("unlocked_15", locked, 1'b0);
      stream(1, -1, -1);
      check_val("locked_16", locked, 1'b1);
      stream(984, -1, -1);
      check_val("clean_err", err_count, 0);
      check_val("clean_bits", bit_count, 984);
      check_val("clean_pulses", n_pulse, 0);

      // Single inverted bit
      do_reset();
      gen = 16'hACE1;
      stream(1000, 199, 199);
      check_val("single_err", err_count, 1);
      check_val("single_pulses", n_pulse, 1);
      check_val("single_locked", locked, 1'b1);
      check_val("single_bits", bit_count, 984);

      // Eight errors within one window
      do_reset();
      gen = 16'hACE1;
      stream(124, 100, 107);
      check_val("burst_err", err_count, 8);
      check_val("burst_locked", locked, 1'b1);
`ifdef PRBS_CHK_LOSS_EN
      check_val("burst_drops", n_drop, 1);
      check_val("burst_bits", bit_count, 92);
`else
      check_val("burst_drops", n_drop, 0);
      check_val("burst_bits", bit_count, 108);
`endif
      stream(500, -1, -1);
      check_val("burst_err_after", err_count, 8);

      // All-zero stream never locks
      do_reset();
      for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("zero_locked", locked, 1'b0);
      check_val("zero_counts", {err_count, bit_count}, 0);
      gen = 16'hACE1;
      stream(300, -1, -1);
      check_val("zero_relock", locked, 1'b1);

      // Clear together with an erroneous bit, then reset mid-check
      do_reset();
      gen = 16'hACE1;
      stream(40, -1, -1);
      stream(20, 5, 9);
      check_val("pre_clear_err", err_count, 5);
      gen_next(b);
      cycle(1'b0, 1'b1, ~b, 1'b1);
      check_val("clear_outputs", {locked, err_pulse, err_count, bit_count},
                {1'b1, 1'b1, CNT_W'(0), CNT_W'(0)});
      stream(10, -1, -1);
      check_val("post_clear_bits", bit_count, 10);
      gen_next(b);
      cycle(1'b1, 1'b1, b, 1'b0);
      check_val("midreset_outputs", {locked, err_pulse, err_count, bit_count}, 64'd0);
      stream(15, -1, -1);
      check_val("resync_15", locked, 1'b0);
      stream(1, -1, -1);
      check_val("resync_16", locked, 1'b1);
      check_val("resync_bits", bit_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
